// File: rtl/loader_pkg.sv
// Shared state encoding and protocol bytes for the UART bus loader.
package loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_COUNT,
        GET_DATA,
        GET_SUM,
        BUS_WR,
        BUS_RD,
        RD_WAIT,
        SEND,
        DONE_ACK,
        TIMEOUT
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    function automatic logic [7:0] byte_sum(input logic [31:0] w);
        return w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endfunction

endpackage

// File: rtl/loader_byte_if.sv
// UART byte handshakes for the loader: rx accept-lock with consume pulse,
// tx send pulse with a short busy holdoff.
module loader_byte_if (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_rd_o,
    output logic [7:0] tx_data_o,
    output logic       tx_wr_o,
    input  logic       tx_busy_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    input  logic       byte_take,
    input  logic       send_req,
    input  logic [7:0] send_data,
    output logic       send_done
);

    logic       lock;
    logic [1:0] hold;
    logic       tx_ready;
    logic       accept;

    assign byte_valid = rx_valid_i && !lock;
    assign byte_data  = rx_data_i;
    assign accept     = byte_valid && byte_take;
    // The transmitter may not raise busy right away, so it is not trusted
    // until two cycles after our own pulse.
    assign tx_ready   = !tx_wr_o && (hold == 2'd0) && !tx_busy_i;
    assign send_done  = tx_wr_o;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rx_rd_o   <= 1'b0;
            lock      <= 1'b0;
            tx_wr_o   <= 1'b0;
            tx_data_o <= 8'h00;
            hold      <= 2'd0;
        end else begin
            rx_rd_o <= accept;
            if (accept)
                lock <= 1'b1;
            else if (!rx_valid_i)
                lock <= 1'b0;

            tx_wr_o <= send_req && tx_ready;
            if (send_req && tx_ready) begin
                tx_data_o <= send_data;
                hold      <= 2'd2;
            end else if (!tx_wr_o && hold != 2'd0) begin
                hold <= hold - 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_bus_loader.sv
// UART-driven bus initiator for program load and debug peek.
// Define LOADER_CHECKSUM_EN to add a modulo-256 data sum to 'W' and 'R'.
module uart_bus_loader
    import loader_pkg::*;
#(
    parameter int FREQ_HZ        = 12000000,
    parameter int TIMEOUT_CYCLES = FREQ_HZ / 10,
    parameter int READ_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_rd_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_wr_o,
    input  logic        tx_busy_i,
    output logic        halt_o,
    output logic [31:0] addr_o,
    output logic        we_o,
    output logic [3:0]  wr_mask_o,
    output logic [31:0] data_out_o,
    input  logic [31:0] data_in_i
);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] LAST_SEND = 3'd4;
`else
    localparam logic [2:0] LAST_SEND = 3'd3;
`endif

    state_t      state;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_take;
    logic        send_req;
    logic [7:0]  send_data;
    logic        send_done;
    logic        got;
    logic        in_get;
    logic        tmo;
    logic        is_rd;
    logic [31:0] sh;
    logic [31:0] word_n;
    logic [31:0] tcnt;
    logic [15:0] count;
    logic [2:0]  idx;
    logic [7:0]  lat;
    logic [7:0]  sum;

    loader_byte_if u_byte_if (
        .clk        (clk),
        .reset_i    (reset_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_rd_o    (rx_rd_o),
        .tx_data_o  (tx_data_o),
        .tx_wr_o    (tx_wr_o),
        .tx_busy_i  (tx_busy_i),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_take  (byte_take),
        .send_req   (send_req),
        .send_data  (send_data),
        .send_done  (send_done)
    );

    assign in_get    = state inside {GET_ADDR, GET_COUNT, GET_DATA, GET_SUM};
    assign byte_take = in_get || (state == IDLE);
    assign got       = byte_valid && byte_take;
    assign word_n    = {byte_data, sh[31:8]};
    assign tmo       = in_get && !got && (tcnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            halt_o     <= 1'b0;
            addr_o     <= 32'h0;
            we_o       <= 1'b0;
            wr_mask_o  <= 4'h0;
            data_out_o <= 32'h0;
            send_req   <= 1'b0;
            send_data  <= 8'h00;
            is_rd      <= 1'b0;
            sh         <= 32'h0;
            tcnt       <= 32'h0;
            count      <= 16'h0;
            idx        <= 3'd0;
            lat        <= 8'h0;
            sum        <= 8'h00;
        end else begin
            tcnt <= (in_get && !got) ? tcnt + 32'd1 : 32'h0;
            if (tmo) begin
                send_req  <= 1'b1;
                send_data <= RSP_NAK;
                state     <= TIMEOUT;
            end else begin
                unique case (state)
                    IDLE: if (got) begin
                        idx   <= 3'd0;
                        sum   <= 8'h00;
                        is_rd <= (byte_data == CMD_READ);
                        if (byte_data == CMD_WRITE || byte_data == CMD_READ) begin
                            halt_o <= 1'b1;
                            state  <= GET_ADDR;
                        end else begin
                            send_req  <= 1'b1;
                            send_data <= RSP_NAK;
                            state     <= DONE_ACK;
                        end
                    end
                    GET_ADDR: if (got) begin
                        sh  <= word_n;
                        idx <= idx + 3'd1;
                        if (idx == 3'd3) begin
                            idx    <= 3'd0;
                            addr_o <= {word_n[31:2], 2'b00};
                            state  <= is_rd ? BUS_RD : GET_COUNT;
                        end
                    end
                    GET_COUNT: if (got) begin
                        sh  <= word_n;
                        idx <= idx + 3'd1;
                        if (idx == 3'd1) begin
                            idx   <= 3'd0;
                            count <= word_n[31:16];
                            if (word_n[31:16] != 16'h0) begin
                                state <= GET_DATA;
                            end else begin
`ifdef LOADER_CHECKSUM_EN
                                state <= GET_SUM;
`else
                                send_req  <= 1'b1;
                                send_data <= RSP_ACK;
                                state     <= DONE_ACK;
`endif
                            end
                        end
                    end
                    GET_DATA: if (got) begin
                        sh  <= word_n;
                        sum <= sum + byte_data;
                        idx <= idx + 3'd1;
                        if (idx == 3'd3) begin
                            idx        <= 3'd0;
                            data_out_o <= word_n;
                            we_o       <= 1'b1;
                            wr_mask_o  <= 4'hF;
                            state      <= BUS_WR;
                        end
                    end
                    BUS_WR: begin
                        we_o      <= 1'b0;
                        wr_mask_o <= 4'h0;
                        addr_o    <= addr_o + 32'd4;
                        count     <= count - 16'd1;
                        if (count != 16'd1) begin
                            state <= GET_DATA;
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            state <= GET_SUM;
`else
                            send_req  <= 1'b1;
                            send_data <= RSP_ACK;
                            state     <= DONE_ACK;
`endif
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    GET_SUM: if (got) begin
                        send_req  <= 1'b1;
                        send_data <= (byte_data == sum) ? RSP_ACK : RSP_NAK;
                        state     <= DONE_ACK;
                    end
`endif
                    BUS_RD: begin
                        lat   <= 8'd1;
                        state <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (lat == 8'(READ_LATENCY)) begin
                            sh        <= {8'h00, data_in_i[31:8]};
                            sum       <= byte_sum(data_in_i);
                            send_req  <= 1'b1;
                            send_data <= data_in_i[7:0];
                            idx       <= 3'd0;
                            state     <= SEND;
                        end else begin
                            lat <= lat + 8'd1;
                        end
                    end
                    SEND: if (send_done) begin
                        idx <= idx + 3'd1;
                        sh  <= {8'h00, sh[31:8]};
                        if (idx == LAST_SEND) begin
                            send_data <= RSP_ACK;
                            state     <= DONE_ACK;
                        end else if (idx == 3'd3) begin
                            send_data <= sum;
                        end else begin
                            send_data <= sh[7:0];
                        end
                    end
                    DONE_ACK, TIMEOUT: if (send_done) begin
                        send_req <= 1'b0;
                        halt_o   <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
